// File: rtl/wall_pkg.sv
// -----------------------------------------------------------------------------
// wall_pkg
// Shared definitions for the wall sprite controller: sprite geometry,
// texel type and the loader state encoding.
// -----------------------------------------------------------------------------
package wall_pkg;

    localparam int         SPRITE_W     = 15;
    localparam int         SPRITE_DEPTH = 225;
    localparam logic [7:0] LAST_ADDR    = 8'(SPRITE_DEPTH - 1);

    typedef logic [1:0] texel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } ld_state_t;

endpackage

// File: rtl/wall_addr_gen.sv
// -----------------------------------------------------------------------------
// wall_addr_gen
// Maps a (col, row) texel coordinate to a linear sprite RAM address
// (row*15 + col) and flags coordinates outside the 15x15 sprite.
//
// Ports
//   col  in  4  texel column
//   row  in  4  texel row
//   addr out 8  linear address, 0 when out of range
//   oor  out 1  coordinate lies outside the sprite
// -----------------------------------------------------------------------------
module wall_addr_gen
    import wall_pkg::*;
(
    input  logic [3:0] col,
    input  logic [3:0] row,
    output logic [7:0] addr,
    output logic       oor
);

    logic [7:0] row_x15;

    assign oor = (col > 4'(SPRITE_W - 1)) || (row > 4'(SPRITE_W - 1));

    // row*15 as (row*16 - row); with row <= 14 the sum never exceeds 224.
    assign row_x15 = {row, 4'b0000} - {4'b0000, row};
    assign addr    = oor ? 8'd0 : (row_x15 + {4'b0000, col});

endmodule

// File: rtl/wall_sprite_ctrl.sv
// -----------------------------------------------------------------------------
// wall_sprite_ctrl
// Sprite RAM controller: serves display texel reads with a fixed two-cycle
// latency and streams full-sprite reloads into the RAM, pausing while
// frame_lock is high.
//
// Build option: define WALL_BYPASS_EN to forward a write that hits the same
// address as a concurrent read into that read's result.
//
// Ports
//   Clk, Reset                  clock, async active-high reset
//   pix_req, pix_col, pix_row   texel read request
//   pix_valid, pix_data         read result, two cycles after the request
//   ld_start, frame_lock        reload start, write inhibit during video
//   ld_valid, ld_data, ld_ready loader stream handshake
//   ld_busy, ld_done            reload in progress, completion pulse
//   mem_we/waddr/wdata          RAM write port
//   mem_raddr/rdata             RAM read port (data one cycle after address)
//
// Loader states
//   state | meaning
//   IDLE  | waiting for ld_start
//   LOAD  | accepting beats, counter = next write address
//   DONE  | one-cycle ld_done pulse, then IDLE
// -----------------------------------------------------------------------------
module wall_sprite_ctrl
    import wall_pkg::*;
#(
    parameter texel_t OOR_TEXEL = 2'd0
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       pix_req,
    input  logic [3:0] pix_col,
    input  logic [3:0] pix_row,
    output logic       pix_valid,
    output texel_t     pix_data,
    input  logic       ld_start,
    input  logic       frame_lock,
    input  logic       ld_valid,
    input  texel_t     ld_data,
    output logic       ld_ready,
    output logic       ld_busy,
    output logic       ld_done,
    output logic       mem_we,
    output logic [7:0] mem_waddr,
    output texel_t     mem_wdata,
    output logic [7:0] mem_raddr,
    input  texel_t     mem_rdata
);

    ld_state_t  state;
    logic [7:0] wr_cnt;
    logic       rd_oor;
    logic       req_q;
    logic       oor_q;
    texel_t     rd_texel;

    wall_addr_gen u_addr_gen (
        .col  (pix_col),
        .row  (pix_row),
        .addr (mem_raddr),
        .oor  (rd_oor)
    );

    // ------------------------------------------------------------------
    // Loader
    // ------------------------------------------------------------------
    assign ld_ready  = (state == LOAD) && !frame_lock;
    assign mem_we    = ld_valid && ld_ready;
    assign mem_waddr = wr_cnt;
    assign mem_wdata = ld_data;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            wr_cnt  <= 8'd0;
            ld_busy <= 1'b0;
            ld_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ld_start) begin
                        state   <= LOAD;
                        wr_cnt  <= 8'd0;
                        ld_busy <= 1'b1;
                    end
                end
                LOAD: begin
                    if (mem_we) begin
                        // Counter parks on the last address; it never wraps.
                        if (wr_cnt == LAST_ADDR) begin
                            state   <= DONE;
                            ld_done <= 1'b1;
                        end else begin
                            wr_cnt <= wr_cnt + 8'd1;
                        end
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    ld_busy <= 1'b0;
                    ld_done <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    ld_busy <= 1'b0;
                    ld_done <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read path: stage 1 lines up with the RAM read, stage 2 registers data
    // ------------------------------------------------------------------
`ifdef WALL_BYPASS_EN
    logic   byp_q;
    texel_t byp_data_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            byp_q      <= 1'b0;
            byp_data_q <= '0;
        end else begin
            byp_q      <= mem_we && (mem_waddr == mem_raddr);
            byp_data_q <= mem_wdata;
        end
    end

    assign rd_texel = byp_q ? byp_data_q : mem_rdata;
`else
    assign rd_texel = mem_rdata;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            req_q     <= 1'b0;
            oor_q     <= 1'b0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
        end else begin
            req_q     <= pix_req;
            oor_q     <= rd_oor;
            pix_valid <= req_q;
            if (req_q) begin
                pix_data <= oor_q ? OOR_TEXEL : rd_texel;
            end
        end
    end

endmodule

// File: tb/tb_wall_sprite_ctrl.sv
module tb_wall_sprite_ctrl;

    localparam logic [1:0] TB_OOR = 2'd2;
`ifdef WALL_BYPASS_EN
    localparam bit         BYP    = 1'b1;
`else
    localparam bit         BYP    = 1'b0;
`endif

    logic       Clk;
    logic       Reset;
    logic       pix_req;
    logic [3:0] pix_col;
    logic [3:0] pix_row;
    logic       pix_valid;
    logic [1:0] pix_data;
    logic       ld_start;
    logic       frame_lock;
    logic       ld_valid;
    logic [1:0] ld_data;
    logic       ld_ready;
    logic       ld_busy;
    logic       ld_done;
    logic       mem_we;
    logic [7:0] mem_waddr;
    logic [1:0] mem_wdata;
    logic [7:0] mem_raddr;
    logic [1:0] mem_rdata;

    wall_sprite_ctrl #(.OOR_TEXEL(TB_OOR)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .pix_req    (pix_req),
        .pix_col    (pix_col),
        .pix_row    (pix_row),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .ld_start   (ld_start),
        .frame_lock (frame_lock),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .ld_busy    (ld_busy),
        .ld_done    (ld_done),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Sprite RAM: synchronous write, registered read returning old data.
    logic [1:0] ram [0:255];
    always @(posedge Clk) begin
        if (mem_we) ram[mem_waddr] <= mem_wdata;
        mem_rdata <= ram[mem_raddr];
    end

    // Reference model state
    logic [1:0] ref_mem [0:255];
    bit         loading;
    bit         done_due;
    int         next_addr;
    bit         sched_v [0:3];
    logic [1:0] sched_d [0:3];
    logic [1:0] last_pd;
    int         cyc;
    int         done_seen;
    int         pv_seen;
    int         n_tests;
    int         n_fail;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Checks one cycle against the model, then advances the model past the edge.
    task automatic tick();
        bit         in_rng;
        int         exp_raddr;
        bit         exp_ready;
        bit         exp_we;
        bit         exp_pv;
        logic [1:0] exp_pd;
        bit         was_idle;
        int         slot;
        int         nslot;
        #1;
        slot = cyc % 4;
        if (Reset) begin
            check_val("rst_pix_valid", pix_valid, 0);
            check_val("rst_pix_data", pix_data, 0);
            check_val("rst_ld_ready", ld_ready, 0);
            check_val("rst_ld_busy", ld_busy, 0);
            check_val("rst_ld_done", ld_done, 0);
            check_val("rst_mem_we", mem_we, 0);
            loading  = 0;
            done_due = 0;
            last_pd  = 2'd0;
            for (int i = 0; i < 4; i++) sched_v[i] = 0;
        end else begin
            in_rng    = (pix_col < 15) && (pix_row < 15);
            exp_raddr = in_rng ? (int'(pix_row) * 15 + int'(pix_col)) : 0;
            exp_ready = loading && !frame_lock;
            exp_we    = ld_valid && exp_ready;
            exp_pv    = sched_v[slot];
            exp_pd    = exp_pv ? sched_d[slot] : last_pd;

            check_val("ld_ready", ld_ready, exp_ready);
            check_val("mem_we", mem_we, exp_we);
            check_val("ld_busy", ld_busy, loading || done_due);
            check_val("ld_done", ld_done, done_due);
            check_val("mem_raddr", mem_raddr, exp_raddr);
            check_val("pix_valid", pix_valid, exp_pv);
            check_val("pix_data", pix_data, exp_pd);
            if (exp_we) begin
                check_val("mem_waddr", mem_waddr, next_addr);
                check_val("mem_wdata", mem_wdata, ld_data);
            end

            last_pd       = exp_pd;
            sched_v[slot] = 0;
            was_idle      = !loading && !done_due;
            done_due      = 0;

            if (pix_req) begin
                nslot = (cyc + 2) % 4;
                sched_v[nslot] = 1;
                if (!in_rng)
                    sched_d[nslot] = TB_OOR;
                else if (BYP && exp_we && next_addr == exp_raddr)
                    sched_d[nslot] = ld_data;
                else
                    sched_d[nslot] = ref_mem[exp_raddr];
            end
            if (exp_we) begin
                ref_mem[next_addr] = ld_data;
                if (next_addr == 224) begin
                    loading  = 0;
                    done_due = 1;
                end else begin
                    next_addr++;
                end
            end
            if (was_idle && ld_start) begin
                loading   = 1;
                next_addr = 0;
            end
        end
        if (ld_done) done_seen++;
        if (pix_valid) pv_seen++;
        cyc++;
        @(negedge Clk);
    endtask

    // mode 0: data i%4, always valid
    // mode 1: random data/gaps, frame_lock held 12 cycles at beat 100
    // mode 2: data (i+3)%4, always valid
    // mode 3: random data, reset at beat 60
    // mode 4: as mode 2 but writes 3 at addr 50 with a concurrent read of 50
    task automatic do_load(input int mode);
        int guard;
        int lock_left;
        bit locked_done;
        bit resume_chk;
        int byp_cyc;
        done_seen   = 0;
        lock_left   = 0;
        locked_done = 0;
        resume_chk  = 0;
        byp_cyc     = -1;
        pix_req    = 0;
        ld_valid   = 0;
        frame_lock = 0;
        ld_start   = 1;
        tick();
        ld_start = 0;
        guard    = 0;
        while (loading && guard < 3000) begin
            guard++;
            pix_req    = 1'($urandom_range(0, 1));
            pix_col    = 4'($urandom_range(0, 15));
            pix_row    = 4'($urandom_range(0, 15));
            ld_start   = ($urandom_range(0, 15) == 0);
            frame_lock = 0;
            ld_valid   = 1;
            case (mode)
                0: ld_data = 2'(next_addr % 4);
                1: begin
                    ld_valid = ($urandom_range(0, 3) != 0);
                    ld_data  = 2'($urandom_range(0, 3));
                    if (next_addr == 100 && !locked_done && lock_left == 0) lock_left = 12;
                    if (lock_left > 0) begin
                        frame_lock = 1;
                        ld_valid   = 1;
                        lock_left--;
                        if (lock_left == 0) begin
                            locked_done = 1;
                            resume_chk  = 1;
                        end
                    end else if (resume_chk) begin
                        ld_valid   = 1;
                        resume_chk = 0;
                        #1;
                        check_val("resume_we", mem_we, 1);
                        check_val("resume_addr", mem_waddr, 100);
                    end
                end
                2: ld_data = 2'((next_addr + 3) % 4);
                4: begin
                    ld_data = 2'((next_addr + 3) % 4);
                    if (next_addr == 50 && byp_cyc < 0) begin
                        ld_data = 2'd3;
                        pix_req = 1;
                        pix_row = 4'd3;
                        pix_col = 4'd5;
                        byp_cyc = cyc + 2;
                    end
                end
                default: begin
                    ld_data = 2'($urandom_range(0, 3));
                    if (next_addr == 60) Reset = 1;
                end
            endcase
            if (cyc == byp_cyc) begin
                #1;
                check_val("bypass_valid", pix_valid, 1);
                check_val("bypass_data", pix_data, BYP ? 2'd3 : 2'd1);
            end
            tick();
            Reset = 0;
        end
        check_val("load_in_bound", guard < 3000, 1);
        ld_valid = 0;
        ld_start = 0;
        pix_req  = 0;
        tick();
        tick();
        tick();
        if (mode == 3) begin
            check_val("no_done_after_rst", done_seen, 0);
            check_val("busy_after_rst", ld_busy, 0);
        end else begin
            check_val("done_pulses", done_seen, 1);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        for (int i = 0; i < 256; i++) begin
            ram[i]     = 2'd0;
            ref_mem[i] = 2'd0;
        end
        mem_rdata  = 2'd0;
        Reset      = 1;
        pix_req    = 0;
        pix_col    = 0;
        pix_row    = 0;
        ld_start   = 0;
        frame_lock = 0;
        ld_valid   = 0;
        ld_data    = 0;
        @(negedge Clk);
        tick();
        tick();
        Reset = 0;
        tick();

        // Full load, data i%4
        do_load(0);

        // Directed read row 2, col 3 -> address 33, texel 33%4
        pix_req = 1;
        pix_row = 4'd2;
        pix_col = 4'd3;
        #1;
        check_val("raddr_r2c3", mem_raddr, 33);
        tick();
        pix_req = 0;
        tick();
        #1;
        check_val("r2c3_valid", pix_valid, 1);
        check_val("r2c3_data", pix_data, 1);
        tick();
        tick();

        // 20 back-to-back out-of-range requests
        pv_seen = 0;
        pix_col = 4'd15;
        for (int i = 0; i < 20; i++) begin
            pix_req = 1;
            pix_row = 4'($urandom_range(0, 15));
            tick();
        end
        pix_req = 0;
        tick();
        tick();
        check_val("oor_valid_count", pv_seen, 20);

        // Random reads
        for (int i = 0; i < 300; i++) begin
            pix_req = 1'($urandom_range(0, 1));
            pix_col = 4'($urandom_range(0, 15));
            pix_row = 4'($urandom_range(0, 15));
            ld_start = 0;
            tick();
        end
        pix_req = 0;
        tick();
        tick();

        // Load with gaps and a frame_lock pause at beat 100
        do_load(1);

        // Set addr 50 to 1, then write 3 there while reading it
        do_load(2);
        do_load(4);

        // Reset mid-load at beat 60, then restart from address 0
        do_load(3);
        do_load(0);

        for (int i = 0; i < 50; i++) begin
            pix_req = 1;
            pix_col = 4'($urandom_range(0, 15));
            pix_row = 4'($urandom_range(0, 15));
            tick();
        end
        pix_req = 0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wall_sprite_ctrl.md
WALL_SPRITE_CTRL -- requirements
Module: wall_sprite_ctrl

Interface
REQ-001 The block SHALL have parameter OOR_TEXEL, default 2'd0: texel returned for an out-of-range pixel request.
REQ-002 The block SHALL have port Clk, input, 1: the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port Reset, input, 1: asynchronous, active-high reset.
REQ-004 The block SHALL have port pix_req, input, 1: display texel request this cycle.
REQ-005 The block SHALL have ports pix_col and pix_row, input, 4 each: texel column and row within the 15x15 sprite.
REQ-006 The block SHALL have port pix_valid, output, 1: pix_data is valid this cycle.
REQ-007 The block SHALL have port pix_data, output, 2: returned texel.
REQ-008 The block SHALL have ports ld_start, input, 1: begin full sprite reload; and frame_lock, input, 1: active video, writes forbidden.
REQ-009 The block SHALL have ports ld_valid, input, 1; ld_data, input, 2; and ld_ready, output, 1: the loader stream handshake.
REQ-010 The block SHALL have ports ld_busy, output, 1: reload in progress; and ld_done, output, 1: one-cycle completion pulse.
REQ-011 The block SHALL have RAM-side ports mem_we, output, 1; mem_waddr, output, 8; mem_wdata, output, 2; mem_raddr, output, 8; and mem_rdata, input, 2 (the RAM returns data one cycle after the address).

Function
REQ-012 mem_raddr SHALL be computed combinationally as pix_row*15+pix_col, using (row<<4)-row and 8-bit arithmetic, with a maximum of 224.
REQ-013 A request SHALL be out of range when pix_col>14 or pix_row>14; mem_raddr is then forced to 0.
REQ-014 A pix_req in cycle N SHALL produce pix_valid=1 in cycle N+2, with pix_data=mem_rdata, or OOR_TEXEL for an out-of-range request. There SHALL be no stall, and back-to-back requests are fully pipelined.
REQ-015 pix_valid and the out-of-range flag SHALL be carried in a 2-stage sideband pipeline. pix_data SHALL hold its last value when pix_valid=0.
REQ-016 The loader FSM SHALL have states IDLE, LOAD and DONE.
REQ-017 IDLE SHALL go to LOAD on ld_start and clear the address counter to 0; ld_start in LOAD or DONE SHALL be ignored.
REQ-018 In LOAD, ld_ready SHALL equal !frame_lock; in IDLE and DONE, ld_ready SHALL be 0.
REQ-019 mem_we SHALL equal ld_valid & ld_ready, with mem_waddr equal to the counter and mem_wdata equal to ld_data.
REQ-020 The counter SHALL increment on each accepted beat. The beat accepted at counter 224 SHALL move the FSM to DONE, and the counter SHALL NOT wrap within a load.
REQ-021 DONE SHALL last exactly one cycle with ld_done=1, then return to IDLE.
REQ-022 ld_busy SHALL be 1 in LOAD and DONE.
REQ-023 frame_lock rising mid-load SHALL pause the load with the counter held, and the load SHALL resume when frame_lock falls.
REQ-024 Reads and writes SHALL proceed in the same cycle without blocking each other.

Reset
REQ-025 On Reset, the FSM SHALL go to IDLE and the counter to 0, and the sideband pipeline SHALL be cleared.
REQ-026 The reset values SHALL be: pix_valid=0, pix_data=0, ld_ready=0, ld_busy=0, ld_done=0, mem_we=0.
REQ-027 Reset mid-load SHALL abandon the load: partially written entries remain, and no ld_done is produced.

Configuration
REQ-028 With WALL_BYPASS_EN defined, a same-cycle write and read to the same address (mem_we=1, mem_waddr==mem_raddr) in cycle N SHALL return the written mem_wdata at N+2.
REQ-029 Without WALL_BYPASS_EN, that case SHALL return the RAM's old data, and no compare logic SHALL be present.

Structure
REQ-030 Package wall_pkg SHALL hold SPRITE_W=15, SPRITE_DEPTH=225, typedef texel_t (2-bit) and the loader state enum.
REQ-031 Sub-module wall_addr_gen SHALL perform the address multiply and the range check; the controller SHALL instantiate it once.

Verification
REQ-032 After Reset, ld_start, then 225 beats of data=i%4 with frame_lock=0: ld_done SHALL pulse once after the 225th beat, with mem_waddr 0..224 in order.
REQ-033 A pix_req with row=2, col=3 SHALL drive mem_raddr=33, and pix_valid SHALL be 1 exactly 2 cycles later with pix_data equal to the stored texel.
REQ-034 A pix_req with col=15 SHALL return pix_valid at +2 with pix_data=OOR_TEXEL; 20 consecutive requests SHALL return 20 consecutive valids.
REQ-035 frame_lock=1 after beat 100 with ld_valid held: ld_ready SHALL be 0 and no writes occur; on release the next write SHALL go to address 100.
REQ-036 A write of 3 to addr 50 concurrent with a read of addr 50 (old value 1) SHALL return 3 with WALL_BYPASS_EN and 1 without it.
REQ-037 Reset asserted at beat 60 SHALL put the FSM in IDLE, with ld_busy=0 and no ld_done; a new ld_start SHALL then restart the load at address 0.
